mult_booth: RTL and testbench

MULT_BOOTH -- requirements
Module: mult_booth

---
 rtl/mult_booth_if.sv | 21 ++
 rtl/mult_booth.sv | 149 ++++++++++++++
 tb/tb_mult_booth.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/mult_booth_if.sv
// Start/operand/result bundle for the radix-2 Booth multiplier.
// The testbench or requester takes the master side, and the multiplier takes the slave side.
interface mult_booth_if;
  logic        ctrl_MULT;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  modport master (
    output ctrl_MULT, data_operandA, data_operandB,
    input  data_result, data_exception, data_resultRDY, busy
  );

  modport slave (
    input  ctrl_MULT, data_operandA, data_operandB,
    output data_result, data_exception, data_resultRDY, busy
  );
endinterface

// File: rtl/mult_booth.sv
// 32x32 signed radix-2 Booth multiplier: one iteration per clock, 32 iterations per product,
// with every add and subtract done by a single shared carry-lookahead adder.
module mult_booth (
  input  logic         clock,
  input  logic         reset_n,
  mult_booth_if.slave  bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d, m_q, m_d;
  logic        q_q, q_d;
  logic [5:0]  count_q, count_d;
  logic [31:0] result_q, result_d;
  logic        exc_q, exc_d, rdy_q, rdy_d;

  logic        do_add, sub_op, add_ovf, shift_in, start;
  logic [31:0] add_b, add_sum, sum_sel, hi_next, lo_next;

  adder_32 u_adder (
    .a        (hi_q),
    .b        (add_b),
    .c_in     (sub_op),
    .sum      (add_sum),
    .overflow (add_ovf)
  );

  // Booth recoding of {LO[0], Q}: 01 adds M, 10 subtracts M as HI + ~M + 1.
  // The shift-in bit is the sign of the true 33-bit sum, so an M of -2^31 is handled without saturating.
  always_comb begin
    do_add   = lo_q[0] ^ q_q;
    sub_op   = lo_q[0] & ~q_q;
    add_b    = sub_op ? ~m_q : m_q;
    sum_sel  = do_add ? add_sum : hi_q;
    shift_in = do_add ? (add_sum[31] ^ add_ovf) : hi_q[31];
    hi_next  = {shift_in, sum_sel[31:1]};
    lo_next  = {sum_sel[0], lo_q[31:1]};
  end

  assign start = bus.ctrl_MULT;

  // NOTE: every variable gets a default at the top of the block, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    q_d      = q_q;
    m_d      = m_q;
    count_d  = count_q;
    result_d = result_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;
    if (start) begin
      // A start in any state reloads the operands, which also aborts an operation in flight.
      state_d = RUN;
      m_d     = bus.data_operandA;
      hi_d    = '0;
      lo_d    = bus.data_operandB;
      q_d     = 1'b0;
      count_d = '0;
    end else begin
      case (state_q)
        RUN: begin
          hi_d    = hi_next;
          lo_d    = lo_next;
          q_d     = lo_q[0];
          count_d = count_q + 6'd1;
          if (count_q == 6'd31) begin
            state_d  = DONE;
            result_d = lo_next;
            exc_d    = (hi_next != {32{lo_next[31]}});
            rdy_d    = 1'b1;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state is written only with non-blocking assignments, so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      hi_q     <= '0;
      lo_q     <= '0;
      q_q      <= 1'b0;
      m_q      <= '0;
      count_q  <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      q_q      <= q_d;
      m_q      <= m_d;
      count_q  <= count_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
    end
  end

  assign bus.data_result    = result_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = rdy_q;
  assign bus.busy           = (state_q == RUN);
endmodule

// 32-bit carry-lookahead adder: 4-bit lookahead groups, with group generate/propagate used to form group carries.
module adder_32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        c_in,
  output logic [31:0] sum,
  output logic        overflow
);
  logic [31:0] g, p;
  logic [32:0] c;
  logic [7:0]  gg, gp;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    c    = '0;
    gg   = '0;
    gp   = '0;
    c[0] = c_in;
    for (int grp = 0; grp < 8; grp++) begin
      gg[grp] = g[4*grp+3] | (p[4*grp+3] & g[4*grp+2])
              | (p[4*grp+3] & p[4*grp+2] & g[4*grp+1])
              | (p[4*grp+3] & p[4*grp+2] & p[4*grp+1] & g[4*grp]);
      gp[grp] = &p[4*grp +: 4];
      c[4*grp+1] = g[4*grp] | (p[4*grp] & c[4*grp]);
      c[4*grp+2] = g[4*grp+1] | (p[4*grp+1] & g[4*grp]) | (p[4*grp+1] & p[4*grp] & c[4*grp]);
      c[4*grp+3] = g[4*grp+2] | (p[4*grp+2] & g[4*grp+1]) | (p[4*grp+2] & p[4*grp+1] & g[4*grp])
                 | (p[4*grp+2] & p[4*grp+1] & p[4*grp] & c[4*grp]);
      c[4*grp+4] = gg[grp] | (gp[grp] & c[4*grp]);
    end
  end

  assign sum      = p ^ c[31:0];
  assign overflow = c[32] ^ c[31];
endmodule

// File: tb/tb_mult_booth.sv
// Directed bench for mult_booth: reset, latency, signed corner products, abort/restart,
// reset in mid-operation, and a chain of back-to-back products checked against a 64-bit product.
module tb_mult_booth;
  logic clock;
  logic reset_n;
  int   n_checks;
  int   n_fail;

  mult_booth_if bus ();

  mult_booth dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge: the start is sampled at the next rising edge (E0).
  // Returns at the falling edge after E0, with random values left on the operand inputs.
  task automatic pulse(input logic [31:0] a, input logic [31:0] b);
    bus.ctrl_MULT     = 1'b1;
    bus.data_operandA = a;
    bus.data_operandB = b;
    @(negedge clock);
    bus.ctrl_MULT     = 1'b0;
    bus.data_operandA = $urandom;
    bus.data_operandB = $urandom;
  endtask

  // Starts at the falling edge after E0, and returns at the falling edge where RDY is seen.
  task automatic await_result(input logic [31:0] exp_res, input logic exp_exc, input string tag);
    int busy_cycles;
    int rdy_at;
    busy_cycles = 0;
    rdy_at      = -1;
    for (int k = 0; k < 40 && rdy_at < 0; k++) begin
      if (bus.busy) busy_cycles++;
      if (bus.data_resultRDY) rdy_at = k;
      if (rdy_at < 0) @(negedge clock);
    end
    check({tag, " rdy latency"}, 64'(rdy_at), 64'd32);
    check({tag, " busy cycles"}, 64'(busy_cycles), 64'd32);
    check({tag, " result"}, {32'd0, bus.data_result}, {32'd0, exp_res});
    check({tag, " exception"}, {63'd0, bus.data_exception}, {63'd0, exp_exc});
  endtask

  // One cycle after DONE: the pulse has ended, the block is idle, and the result is held.
  task automatic check_idle_hold(input logic [31:0] exp_res, input string tag);
    @(negedge clock);
    check({tag, " rdy pulse width"}, {63'd0, bus.data_resultRDY}, 64'd0);
    check({tag, " busy after done"}, {63'd0, bus.busy}, 64'd0);
    check({tag, " result held"}, {32'd0, bus.data_result}, {32'd0, exp_res});
  endtask

  initial begin
    logic [31:0] corner [5];
    logic [31:0] ra, rb;
    longint      prod;
    logic [63:0] prod_bits;
    int          rdy_seen;

    n_checks = 0;
    n_fail   = 0;
    corner[0] = 32'h0000_0000;
    corner[1] = 32'h0000_0001;
    corner[2] = 32'hFFFF_FFFF;
    corner[3] = 32'h8000_0000;
    corner[4] = 32'h7FFF_FFFF;

    reset_n           = 1'b0;
    bus.ctrl_MULT     = 1'b0;
    bus.data_operandA = '0;
    bus.data_operandB = '0;
    repeat (3) @(negedge clock);
    check("reset result", {32'd0, bus.data_result}, 64'd0);
    check("reset exception", {63'd0, bus.data_exception}, 64'd0);
    check("reset rdy", {63'd0, bus.data_resultRDY}, 64'd0);
    check("reset busy", {63'd0, bus.busy}, 64'd0);

    // A start is already asserted when reset releases, so it is taken at the first rising edge.
    reset_n = 1'b1;
    pulse(32'd6, 32'd7);
    await_result(32'd42, 1'b0, "6x7");
    check_idle_hold(32'd42, "6x7");

    @(negedge clock);
    pulse(32'hFFFF_FFFD, 32'd5);
    await_result(32'hFFFF_FFF1, 1'b0, "-3x5");
    check_idle_hold(32'hFFFF_FFF1, "-3x5");

    pulse(32'h7FFF_FFFF, 32'hFFFF_FFFF);
    await_result(32'h8000_0001, 1'b0, "maxpos x -1");
    check_idle_hold(32'h8000_0001, "maxpos x -1");

    pulse(32'h8000_0000, 32'hFFFF_FFFF);
    await_result(32'h8000_0000, 1'b1, "minneg x -1");
    check_idle_hold(32'h8000_0000, "minneg x -1");

    pulse(32'h0001_0000, 32'h0001_0000);
    await_result(32'h0000_0000, 1'b1, "2^16 x 2^16");
    check_idle_hold(32'h0000_0000, "2^16 x 2^16");

    // A restart at E0+10 aborts the first product; only the second product reports.
    pulse(32'd6, 32'd7);
    rdy_seen = 0;
    repeat (9) begin
      @(negedge clock);
      if (bus.data_resultRDY) rdy_seen++;
    end
    pulse(32'd2, 32'd3);
    check("abort no early rdy", 64'(rdy_seen), 64'd0);
    await_result(32'd6, 1'b0, "abort restart 2x3");
    check_idle_hold(32'd6, "abort restart 2x3");

    // Asserting reset mid-operation clears the outputs at once, and no result follows.
    pulse(32'd9, 32'd9);
    repeat (14) @(negedge clock);
    @(posedge clock);
    #1 reset_n = 1'b0;
    #1;
    check("midreset result", {32'd0, bus.data_result}, 64'd0);
    check("midreset exception", {63'd0, bus.data_exception}, 64'd0);
    check("midreset rdy", {63'd0, bus.data_resultRDY}, 64'd0);
    check("midreset busy", {63'd0, bus.busy}, 64'd0);
    @(negedge clock);
    reset_n  = 1'b1;
    rdy_seen = 0;
    repeat (40) begin
      @(negedge clock);
      if (bus.data_resultRDY) rdy_seen++;
    end
    check("midreset no rdy", 64'(rdy_seen), 64'd0);

    // Back-to-back chain: each start lands in the DONE cycle of the previous product.
    pulse(32'h8000_0000, 32'h8000_0000);
    await_result(32'h0000_0000, 1'b1, "minneg x minneg");
    for (int i = 0; i < 64; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
      prod      = longint'($signed(ra)) * longint'($signed(rb));
      prod_bits = prod;
      pulse(ra, rb);
      await_result(prod_bits[31:0], (prod_bits[63:31] != {33{prod_bits[31]}}), $sformatf("chain %0d", i));
    end
    check_idle_hold(prod_bits[31:0], "chain end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
